// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// fetch_pc_unit : fetch-stage PC owner, branch redirect, flush strobes.
// Optional target alignment check: FETCH_MISALIGN_CHECK_EN.   Rev 1.0
// ============================================================================
module fetch_pc_unit #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic [PC_W-1:0] Fetch_PC,
  output logic            IfId_Valid,
  output logic            Flush_IfId,
  output logic            Flush_IdEx,
  output logic [15:0]     Redirect_Cnt,
  output logic            Misalign_Err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    REDIR = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] target;
  logic            valid_next;
  logic [15:0]     cnt_next;
  logic            misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target   = {BrPC[PC_W-1:2], 2'b00};
  assign misalign = |BrPC[1:0];
`else
  assign target   = BrPC[PC_W-1:0];
  assign misalign = 1'b0;
`endif

  // Both wrong-path slots die on the same edge the redirect target is loaded.
  assign Flush_IfId = PcSel & ~reset;
  assign Flush_IdEx = PcSel & ~reset;

  always_comb begin
    state_next = state;
    pc_next    = Fetch_PC;
    valid_next = IfId_Valid;
    cnt_next   = Redirect_Cnt;
    if (PcSel) begin
      state_next = REDIR;
      pc_next    = target;
      valid_next = 1'b0;
      cnt_next   = (Redirect_Cnt == 16'hFFFF) ? Redirect_Cnt : Redirect_Cnt + 16'd1;
    end else if (Stall) begin
      state_next = HOLD;
    end else begin
      state_next = RUN;
      pc_next    = Fetch_PC + PC_W'(4);
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      Fetch_PC     <= RESET_PC;
      IfId_Valid   <= 1'b0;
      Redirect_Cnt <= 16'd0;
    end else begin
      state        <= state_next;
      Fetch_PC     <= pc_next;
      IfId_Valid   <= valid_next;
      Redirect_Cnt <= cnt_next;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)
      Misalign_Err <= 1'b0;
    else if (PcSel && misalign)
      Misalign_Err <= 1'b1;
  end
`else
  assign Misalign_Err = misalign;
`endif

  // Target bits above the PC width are discarded by design.
  generate
    if (PC_W < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^BrPC[31:PC_W];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_pc_unit : self-checking bench for fetch_pc_unit.   Rev 1.0
// ============================================================================
module tb_fetch_pc_unit;

  localparam int PC_W   = 9;
  localparam int RST_PC = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            Stall = 1'b0;
  logic            PcSel = 1'b0;
  logic [31:0]     BrPC = 32'd0;
  logic [PC_W-1:0] Fetch_PC;
  logic            IfId_Valid;
  logic            Flush_IfId;
  logic            Flush_IdEx;
  logic [15:0]     Redirect_Cnt;
  logic            Misalign_Err;

  fetch_pc_unit #(.PC_W(PC_W), .RESET_PC(9'(RST_PC))) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .PcSel(PcSel), .BrPC(BrPC),
    .Fetch_PC(Fetch_PC), .IfId_Valid(IfId_Valid), .Flush_IfId(Flush_IfId),
    .Flush_IdEx(Flush_IdEx), .Redirect_Cnt(Redirect_Cnt), .Misalign_Err(Misalign_Err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, advanced once per clock edge from the rules.
  int m_pc  = RST_PC;
  bit m_v   = 0;
  int m_cnt = 0;
  bit m_err = 0;

  typedef struct {
    bit        r, s, p;
    logic [31:0] b;
    int        pc;
    bit        v;
    int        cnt;
    bit        err;
    bit        fl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit s, bit p, logic [31:0] b,
                              int pc, bit v, int cnt, bit err, bit fl);
    vec_t t;
    t.r = r; t.s = s; t.p = p; t.b = b;
    t.pc = pc; t.v = v; t.cnt = cnt; t.err = err; t.fl = fl;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit p, input logic [31:0] b);
    int tgt;
    if (r) begin
      m_pc = RST_PC; m_v = 0; m_cnt = 0; m_err = 0;
    end else if (p) begin
      tgt = int'(b % (32'd1 << PC_W));
      if (MC && (b % 4 != 0)) begin
        tgt   = tgt - (tgt % 4);
        m_err = 1;
      end
      m_pc  = tgt;
      m_v   = 0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else if (!s) begin
      m_pc = (m_pc + 4) % (1 << PC_W);
      m_v  = 1;
    end
  endtask

  // Drive one cycle: inputs at negedge, sample strobes, then take the edge.
  task automatic apply(input bit r, input bit s, input bit p, input logic [31:0] b,
                       output bit f1, output bit f2);
    @(negedge clk);
    reset = r; Stall = s; PcSel = p; BrPC = b;
    #1;
    f1 = Flush_IfId;
    f2 = Flush_IdEx;
    @(posedge clk);
    #1;
    model_edge(r, s, p, b);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pc"},    32'(Fetch_PC),     32'(m_pc));
    chk({tag, "_valid"}, 32'(IfId_Valid),   32'(m_v));
    chk({tag, "_cnt"},   32'(Redirect_Cnt), 32'(m_cnt));
    chk({tag, "_err"},   32'(Misalign_Err), 32'(m_err));
  endtask

  initial begin
    bit f1, f2;
    bit r, s, p;
    logic [31:0] b;

    tbl.push_back(mk(1,0,0,32'h0,   'h000,0,0,0,0));
    tbl.push_back(mk(1,0,0,32'h0,   'h000,0,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,   'h004,1,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,   'h008,1,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,   'h00C,1,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,   'h010,1,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,   'h010,1,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,   'h010,1,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,   'h010,1,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,   'h014,1,0,0,0));
    tbl.push_back(mk(0,1,1,32'h40,  'h040,0,1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,   'h044,1,1,0,0));
    tbl.push_back(mk(0,0,1,32'h80,  'h080,0,2,0,1));
    tbl.push_back(mk(0,0,1,32'h20,  'h020,0,3,0,1));
    tbl.push_back(mk(0,0,0,32'h0,   'h024,1,3,0,0));
    tbl.push_back(mk(0,0,1,32'h304, 'h104,0,4,0,1));
    tbl.push_back(mk(0,1,0,32'h0,   'h104,0,4,0,0));
    tbl.push_back(mk(0,0,0,32'h0,   'h108,1,4,0,0));
    tbl.push_back(mk(1,1,1,32'h80,  'h000,0,0,0,0));
    tbl.push_back(mk(0,0,1,32'h1FC, 'h1FC,0,1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,   'h000,1,1,0,0));
    tbl.push_back(mk(0,0,1,32'h42,  MC ? 'h040 : 'h042,0,2,MC,1));
    tbl.push_back(mk(0,0,0,32'h0,   MC ? 'h044 : 'h046,1,2,MC,0));
    tbl.push_back(mk(0,0,1,32'h100, 'h100,0,3,MC,1));
    tbl.push_back(mk(1,0,0,32'h0,   'h000,0,0,0,0));

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].b, f1, f2);
      chk($sformatf("tbl%0d_flush_ifid", i), 32'(f1), 32'(tbl[i].fl));
      chk($sformatf("tbl%0d_flush_idex", i), 32'(f2), 32'(tbl[i].fl));
      chk($sformatf("tbl%0d_pc", i),    32'(Fetch_PC),     32'(tbl[i].pc));
      chk($sformatf("tbl%0d_valid", i), 32'(IfId_Valid),   32'(tbl[i].v));
      chk($sformatf("tbl%0d_cnt", i),   32'(Redirect_Cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_err", i),   32'(Misalign_Err), 32'(tbl[i].err));
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 3) == 0);
      b = $urandom;
      if ($urandom_range(0, 1) == 0) b[1:0] = 2'b00;
      apply(r, s, p, b, f1, f2);
      chk("rnd_flush_ifid", 32'(f1), 32'(p && !r));
      chk("rnd_flush_idex", 32'(f2), 32'(p && !r));
      chk_model("rnd");
    end

    // Redirect counter saturation.
    apply(1, 0, 0, 32'h0, f1, f2);
    chk_model("sat_reset");
    for (int i = 1; i <= 65540; i++) begin
      apply(0, 0, 1, {$urandom_range(0, 127), 2'b00}, f1, f2);
      if (i == 65534) chk("sat_cnt_fffe", 32'(Redirect_Cnt), 32'h0000FFFE);
      if (i == 65535) chk("sat_cnt_ffff", 32'(Redirect_Cnt), 32'h0000FFFF);
    end
    chk("sat_cnt_hold", 32'(Redirect_Cnt), 32'h0000FFFF);
    chk_model("sat_end");
    apply(0, 0, 0, 32'h0, f1, f2);
    chk_model("sat_seq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

- Fetch-stage program-counter owner and consumer of the execute-stage branch redirect (`PcSel` / `BrPC`).
- Holds the fetch PC and drives the instruction-memory address. Advances by 4, holds on hazard stall, and loads the redirect target when a branch or jump is taken.
- Generates the IF/ID and ID/EX flush strobes, the IF/ID valid bit and a saturating redirect counter.
- Sits between the hazard unit, the branch unit in EX, and instruction memory.

## Interface
Parameters:
- `PC_W`, 9, width of the fetch PC and instruction address.
- `RESET_PC`, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Stall`  in  1  hazard-unit request to hold the PC and IF/ID.
- `PcSel`  in  1  taken-branch/jump redirect request from EX.
- `BrPC`  in  32  redirect target; only meaningful when `PcSel`=1.
- `Fetch_PC`  out  PC_W  registered instruction-memory address.
- `IfId_Valid`  out  1  registered; the IF/ID register holds a valid instruction.
- `Flush_IfId`  out  1  combinational; bubble IF/ID this edge.
- `Flush_IdEx`  out  1  combinational; bubble ID/EX this edge.
- `Redirect_Cnt`  out  16  registered count of accepted redirects, saturating.
- `Misalign_Err`  out  1  registered sticky flag for a misaligned target.

## Operation
FSM states: `BOOT`, `RUN`, `HOLD`, `REDIR`. Each rising edge with `reset`=0 is evaluated in this priority order:
- **`PcSel`=1 (highest priority, any state):**
  - `Fetch_PC` <= `BrPC[PC_W-1:0]`, with the target rule below.
  - Next state is `REDIR`; `IfId_Valid` <= 0.
  - `Redirect_Cnt` increments, saturating at 0xFFFF.
  - `Stall` is ignored.
- **Otherwise, `Stall`=1:** `Fetch_PC` and `IfId_Valid` hold. Next state is `HOLD`.
- **Otherwise:** `Fetch_PC` <= `Fetch_PC`+4, modulo 2^PC_W (wraps silently). `IfId_Valid` <= 1. Next state is `RUN`.

State meaning:
- `BOOT`: the first cycle after reset release.
- `REDIR`: the first fetch from a redirect target.
- `HOLD`: frozen.
- `RUN`: sequential fetch.

Flush outputs:
- `Flush_IfId` = `Flush_IdEx` = `PcSel` & ~`reset`.
- Both wrong-path slots (IF and ID) are killed at the same edge the target is loaded.

Other rules:
- `BrPC` bits above PC_W-1 are discarded, with no error.
- Back-to-back `PcSel` (also asserted in `REDIR`) is legal: the newest target wins, the state stays `REDIR`, and the counter increments again.

## Timing
- Reset (edge with `reset`=1) sets: `Fetch_PC`=`RESET_PC`, state `BOOT`, `IfId_Valid`=0, `Redirect_Cnt`=0, `Misalign_Err`=0.
- During reset, `Flush_IfId` and `Flush_IdEx` are 0 regardless of `PcSel`.
- Reset asserted mid-redirect or mid-stall overrides everything in that cycle.
- Redirect latency: `PcSel` sampled at edge N gives `Fetch_PC`=target from edge N onward, and the first target instruction is in IF/ID after edge N+1.
- Stall: no PC change for as long as `Stall`=1 with `PcSel`=0. Release resumes at `Fetch_PC`+4 on the next edge.
- The first fetch after reset is at `RESET_PC`. `IfId_Valid` rises after the first non-stalled edge.
- All outputs except the flush strobes are flop outputs; there is no combinational path from inputs to them.

## Configuration
`FETCH_MISALIGN_CHECK_EN`:
- **Defined:** on an accepted redirect with `BrPC[1:0]`≠0:
  - `Misalign_Err` is set and stays set until reset.
  - `Fetch_PC` loads the target with bits [1:0] cleared.
- **Undefined:**
  - `Misalign_Err` is tied 0.
  - The target is loaded unmodified, including its low bits. Later increments then stay misaligned.

## Test plan
- Reset for 2 cycles, then release for 3 free-running cycles -> `Fetch_PC` 0→4→8→12, `IfId_Valid` 0 then 1, `Redirect_Cnt`=0, flush strobes never high.
- `Stall`=1 for 3 cycles at `Fetch_PC`=0x10 -> `Fetch_PC` holds 0x10. First edge after release gives 0x14.
- `PcSel`=1, `BrPC`=0x40, `Stall`=1 in the same cycle -> both flushes high that cycle. `Fetch_PC`=0x40 next, `IfId_Valid`=0 for one cycle, `Redirect_Cnt`=1.
- Back-to-back `PcSel` with targets 0x80 then 0x20 -> `Fetch_PC`=0x80 then 0x20, `Redirect_Cnt`+2, then 0x24 sequential.
- `Fetch_PC`=0x1FC with `PC_W`=9, no stall -> wraps to 0x000. `BrPC`=0x0000_0304 -> `Fetch_PC`=0x104.
- `BrPC`=0x42:
  - With `FETCH_MISALIGN_CHECK_EN`: `Fetch_PC`=0x40 and `Misalign_Err`=1, held through later redirects until reset.
  - Without it: `Fetch_PC`=0x42 and `Misalign_Err`=0.
- Drive 65,540 redirects -> `Redirect_Cnt` saturates at 0xFFFF.
